// File: rtl/aes_round_ctrl_pkg.sv
// aes_round_ctrl_pkg: FSM encodings, round constants and GF(2^8) helpers shared by the AES round controller.
package aes_round_ctrl_pkg;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [7:0] RCON_INIT_DEF = 8'h01;
   localparam int AES_NR = 10;
   localparam logic [7:0] XTIME_POLY = 8'h1b;
   // byte x of the S-box sits at bits [2047-8x -: 8]
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? XTIME_POLY : 8'h00);
   endfunction
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[2047 - 8 * int'(x) -: 8];
   endfunction
   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction
endpackage

// File: rtl/addRoundKey.sv
// addRoundKey: AES AddRoundKey.
module addRoundKey (
   input  logic [127:0] din,
   input  logic [127:0] rkey,
   output logic [127:0] dout
);
   assign dout = din ^ rkey;
endmodule

// File: rtl/expandKey.sv
// expandKey: one AES-128 key-schedule step producing the next round key from the current one.
module expandKey
   import aes_round_ctrl_pkg::*;
(
   input  logic [127:0] key_i,
   input  logic [7:0]   rcon,
   output logic [127:0] key_o
);
   logic [31:0] t, w0, w1, w2, w3;
   assign t  = {sbox(key_i[23:16]) ^ rcon, sbox(key_i[15:8]), sbox(key_i[7:0]), sbox(key_i[31:24])};
   assign w0 = key_i[127:96] ^ t;
   assign w1 = key_i[95:64] ^ w0;
   assign w2 = key_i[63:32] ^ w1;
   assign w3 = key_i[31:0] ^ w2;
   assign key_o = {w0, w1, w2, w3};
endmodule

// File: rtl/roundFunc1to9.sv
// roundFunc1to9: full AES round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with its key expansion.
module roundFunc1to9
   import aes_round_ctrl_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] key_i,
   input  logic [7:0]   rcon,
   output logic [127:0] state_o,
   output logic [127:0] key_o
);
   logic [127:0] sb, sr, mc;
   subBytes128 u_sb (.din(state_i), .dout(sb));
   shift128 u_sr (.din(sb), .dout(sr));
   for (genvar c = 0; c < 4; c++) begin : g_mc
      assign mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
   end
   expandKey u_ek (.key_i(key_i), .rcon(rcon), .key_o(key_o));
   addRoundKey u_ark (.din(mc), .rkey(key_o), .dout(state_o));
endmodule

// File: rtl/shift128.sv
// shift128: AES ShiftRows; byte i is row i%4, column i/4, row r rotates left by r.
module shift128 (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   for (genvar i = 0; i < 16; i++) begin : g_b
      assign dout[127-8*i -: 8] = din[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8];
   end
endmodule

// File: rtl/subBytes128.sv
// subBytes128: AES SubBytes applied to all 16 bytes of a block.
module subBytes128
   import aes_round_ctrl_pkg::*;
(
   input  logic [127:0] din,
   output logic [127:0] dout
);
   for (genvar i = 0; i < 16; i++) begin : g_b
      assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
   end
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryptor, one round per clock, 10-clock latency.
// Define AES_KEY_REUSE_EN to add key_load and a retained cipher-key register.
module aes_round_ctrl
   import aes_round_ctrl_pkg::*;
#(
   parameter logic [7:0] RCON_INIT = RCON_INIT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
`ifdef AES_KEY_REUSE_EN
   input  logic         key_load,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);
   logic [1:0]   fsm_q, fsm_d;
   logic [127:0] data_q, data_d, rk_q, rk_d, key_sel;
   logic [127:0] rf_state, rf_key, fin_sb, fin_sr, fin_key, fin_state;
   logic [7:0]   rcon_q, rcon_d;
   logic [3:0]   round_q, round_d;
   logic         accept;
   assign in_ready   = fsm_q == S_IDLE;
   assign busy       = fsm_q == S_RUN || fsm_q == S_FINAL;
   assign out_valid  = fsm_q == S_DONE;
   assign ciphertext = data_q;
   assign accept     = in_valid & in_ready;
`ifdef AES_KEY_REUSE_EN
   logic [127:0] ckey_q, ckey_d;
   assign ckey_d  = accept && key_load ? key : ckey_q;
   assign key_sel = key_load ? key : ckey_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) ckey_q <= '0;
      else ckey_q <= ckey_d;
`else
   assign key_sel = key;
`endif
   roundFunc1to9 u_round (.state_i(data_q), .key_i(rk_q), .rcon(rcon_q), .state_o(rf_state), .key_o(rf_key));
   // last round skips MixColumns; rcon_q has reached 8'h36 by now
   subBytes128 u_fin_sb (.din(data_q), .dout(fin_sb));
   shift128 u_fin_sr (.din(fin_sb), .dout(fin_sr));
   expandKey u_fin_ek (.key_i(rk_q), .rcon(rcon_q), .key_o(fin_key));
   addRoundKey u_fin_ark (.din(fin_sr), .rkey(fin_key), .dout(fin_state));
   always_comb begin
      fsm_d   = fsm_q;
      data_d  = data_q;
      rk_d    = rk_q;
      rcon_d  = rcon_q;
      round_d = round_q;
      if (accept) begin
         fsm_d   = S_RUN;
         data_d  = plaintext ^ key_sel;
         rk_d    = key_sel;
         rcon_d  = RCON_INIT;
         round_d = 4'd1;
      end else if (fsm_q == S_RUN) begin
         fsm_d   = round_q == 4'(AES_NR - 1) ? S_FINAL : S_RUN;
         data_d  = rf_state;
         rk_d    = rf_key;
         rcon_d  = xtime(rcon_q);
         round_d = round_q + 4'd1;
      end else if (fsm_q == S_FINAL) begin
         fsm_d  = S_DONE;
         data_d = fin_state;
         rk_d   = fin_key;
      end else if (fsm_q == S_DONE && out_ready) begin
         fsm_d = S_IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fsm_q   <= S_IDLE;
         data_q  <= '0;
         rk_q    <= '0;
         rcon_q  <= RCON_INIT;
         round_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         data_q  <= data_d;
         rk_q    <= rk_d;
         rcon_q  <= rcon_d;
         round_q <= round_d;
      end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: known-answer table, directed corner sequences and random blocks checked
// against a byte-array AES model whose S-box is derived from the GF(2^8) inverse.
module tb_aes_round_ctrl;
   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      int           stall;
   } vec_t;

   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid, busy;
   logic [127:0] plaintext = '0, key = '0, ciphertext;
`ifdef AES_KEY_REUSE_EN
   logic key_load = 1;
`endif
   int checks = 0, errors = 0;
   logic [7:0] sbox_t [256];
   vec_t vecs [4];

   aes_round_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .plaintext(plaintext), .key(key),
`ifdef AES_KEY_REUSE_EN
      .key_load(key_load),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) if (b[i]) m ^= 15'(a) << i;
      for (int i = 14; i >= 8; i--) if (m[i]) m ^= 15'h11b << (i - 8);
      return m[7:0];
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] rk [176];
      logic [7:0] w [4];
      logic [7:0] rc;
      logic [127:0] r;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         rk[i] = k[127-8*i -: 8];
         s[i]  = p[127-8*i -: 8] ^ rk[i];
      end
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) w[j] = rk[i-4+j];
         if (i % 16 == 0) begin
            for (int j = 0; j < 4; j++) t[j] = w[j];
            for (int j = 0; j < 4; j++) w[j] = sbox_t[t[(j+1)%4]];
            w[0] ^= rc;
            rc = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ w[j];
      end
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*((i/4 + i%4) % 4)]];
         for (int i = 0; i < 16; i++) s[i] = t[i];
         if (rnd < 10)
            for (int c = 0; c < 4; c++)
               for (int row = 0; row < 4; row++) begin
                  s[4*c+row] = 8'h00;
                  for (int m = 0; m < 4; m++)
                     s[4*c+row] ^= gmul((m-row+4)%4 == 0 ? 8'h02 : (m-row+4)%4 == 1 ? 8'h03 : 8'h01, t[4*c+m]);
               end
         for (int i = 0; i < 16; i++) s[i] ^= rk[16*rnd+i];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   task automatic run_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e, input int stall);
      int n;
      logic [127:0] held;
      n = 0;
      while (!in_ready && n < 30) begin
         step();
         n++;
      end
      check("idle_wait", 128'(in_ready), 128'(1));
      in_valid = 1;
      key = k;
      plaintext = p;
      step();
      check("accept_flags", {126'd0, busy, in_ready}, 128'b10);
      n = 0;
      while (!out_valid && n < 20) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         plaintext = {$urandom, $urandom, $urandom, $urandom};
         step();
         n++;
      end
      check("latency", 128'(n), 128'(10));
      check("ct", ciphertext, e);
      held = ciphertext;
      for (int i = 0; i < stall; i++) begin
         step();
         check("hold_ct", ciphertext, held);
         check("hold_flags", {125'd0, out_valid, in_ready, busy}, 128'b100);
      end
      out_ready = 1;
      step();
      check("leave_flags", {126'd0, out_valid, in_ready}, 128'b01);
      in_valid = 0;
      out_ready = 0;
   endtask

   task automatic back_to_back();
      logic [127:0] got [$];
      int acc [$];
      int idx;
      idx = 0;
      out_ready = 1;
      for (int cyc = 0; cyc < 40 && got.size() < 2; cyc++) begin
         if (idx < 2) begin
            in_valid = 1;
            key = vecs[idx].key;
            plaintext = vecs[idx].pt;
         end else in_valid = 0;
         if (in_valid && in_ready) begin
            acc.push_back(cyc);
            idx++;
         end
         if (out_valid) got.push_back(ciphertext);
         step();
      end
      in_valid = 0;
      out_ready = 0;
      check("b2b_accepts", 128'(acc.size()), 128'(2));
      check("b2b_outputs", 128'(got.size()), 128'(2));
      if (acc.size() == 2) check("b2b_spacing", 128'(acc[1] - acc[0]), 128'(12));
      if (got.size() == 2) begin
         check("b2b_ct0", got[0], vecs[0].ct);
         check("b2b_ct1", got[1], vecs[1].ct);
      end
   endtask

   initial begin
      logic spurious;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         logic [15:0] bb;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         bb = {inv, inv};
         sbox_t[x] = inv ^ bb[14:7] ^ bb[13:6] ^ bb[12:5] ^ bb[11:4] ^ 8'h63;
      end
      vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                  ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, stall: 0};
      vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                  ct: 128'h3925841d02dc09fbdc118597196a0b32, stall: 2};
      vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, stall: 0};
      vecs[3] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                  ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, stall: 5};

      step();
      step();
      check("rst_flags", {125'd0, in_ready, out_valid, busy}, 128'b100);
      check("rst_ct", ciphertext, 128'h0);
      rst = 0;

      for (int i = 0; i < 4; i++) run_block(vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].stall);

      in_valid = 1;
      key = vecs[0].key;
      plaintext = vecs[0].pt;
      step();
      in_valid = 0;
      repeat (4) step();
      check("mid_busy", 128'(busy), 128'(1));
      rst = 1;
      #1;
      check("rst_async_flags", {125'd0, out_valid, in_ready, busy}, 128'b010);
      check("rst_async_ct", ciphertext, 128'h0);
      step();
      rst = 0;
      spurious = 0;
      repeat (12) begin
         step();
         if (out_valid) spurious = 1;
      end
      check("no_spurious", 128'(spurious), 128'(0));
      run_block(vecs[0].key, vecs[0].pt, vecs[0].ct, 0);

      back_to_back();

      for (int i = 0; i < 6; i++) begin
         logic [127:0] k, p;
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         run_block(k, p, aes_ref(k, p), int'($urandom_range(0, 3)));
      end

`ifdef AES_KEY_REUSE_EN
      key_load = 1;
      run_block(vecs[1].key, vecs[1].pt, vecs[1].ct, 0);
      key_load = 0;
      run_block(128'h0, vecs[1].pt, vecs[1].ct, 0);
      run_block({$urandom, $urandom, $urandom, $urandom}, vecs[1].pt, vecs[1].ct, 1);
      key_load = 1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
